hexdisp_arb: RTL
================

# hexdisp_arb

Round-robin arbiter that shares the board's eight seven-segment digits between four requesters, each wanting to show a 16-bit value. A granted requester owns the display for a minimum dwell time, so a human can read it. Its live value is driven onto hex digits 0–3 and its index onto digit 4. It sits between free-running counter/status blocks and the top-level `hex` pins, replacing direct per-block `hexdigit` wiring.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz, documentation and default source only.
- `DWELL`, default `CLK_FREQ`: minimum ownership in cycles; legal range ≥ 2; a bench uses 4.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req` in 4: request per requester, level-sensitive.
- `val` in 64: requester i value at `val[16*i+15:16*i]`.
- `gnt` out 4: one-hot grant, or all zero when idle; registered.
- `active` out 1: high when any grant is held; registered.
- `owner` out 2: index of current/last owner; registered.
- `hex` out 56: 8 digits × 7 segments, digit d at `hex[7*d+6:7*d]`.

## Operation
- Two states, IDLE and HOLD. A dwell counter `dcnt` of $clog2(DWELL) bits clears on every grant change.
- **Reset (async):** state IDLE, `gnt`=0, `active`=0, `owner`=3, `dcnt`=0, shown value register `shown`=16'h0000. With `owner`=3 after reset, requester 0 has the highest priority.
- **Priority:** the search order starts at `(owner+1) mod 4` and wraps, so the current owner is always last.
- **IDLE:**
  - If any `req` is set, grant the first set bit in priority order and enter HOLD.
  - Otherwise stay in IDLE. `shown` and `owner` keep their last values.
- **HOLD:**
  - Each cycle, `shown` ← owner's `val` slice, so the display tracks the value live.
  - `dcnt` increments and saturates at DWELL-1.
- **Owner drops `req` before expiry:** release on the next edge. The same edge rearbitrates among the other requesters. If one is requesting, grant it and stay in HOLD with `dcnt`=0. Otherwise go to IDLE with `gnt`=0 and `active`=0.
- **Expiry (`dcnt`==DWELL-1):**
  - If another requester has `req` set, switch to it and clear `dcnt`.
  - Otherwise, if the owner still requests, keep it with `dcnt` held saturated, so a new request switches on the next edge.
  - If no requests remain, go to IDLE.
- **Simultaneous requests:** resolved purely by the round-robin order. Ties never stall.
- **Display mapping:**
  - Digits 0–3 are driven by `hexdigit` from `shown` nibbles [3:0], [7:4], [11:8], [15:12].
  - Digit 4 is driven by `hexdigit` from `{2'b0, owner}`.
  - Digits 5–7 are driven with constant 0.
  - All digit paths are combinational from registers.
- **Reset mid-HOLD:** immediate return to the reset values. The first grant after reset goes to the lowest-index requester.

## Timing
- Request to grant: `gnt`, `active`, `owner` and `shown` update on the first rising edge that samples `req`, so latency is 1 cycle.
- `hex` for the new owner is valid in the same cycle that `gnt` is.
- Value tracking: a change on the owner's `val` appears on `hex` 1 cycle later.
- A continuously contended owner holds exactly DWELL cycles, then switches; no dead cycle between owners.
- Release: `req` deasserted at edge k means `gnt` changes at edge k+1.
- `gnt` is never multi-hot. `active` equals `|gnt` at all times.

## Test plan
- **Reset** (DWELL=4): assert `rst` asynchronously mid-cycle → `gnt`=0, `active`=0, `owner`=3, digits 0–3 show 0, digit 4 shows 3, immediately and without a clock edge.
- **Single requester:** `req`=4'b0100, `val` slice 2 = 16'hBEEF → after 1 edge `gnt`=4'b0100, `owner`=2, digits show F,E,E,B,2. Changing the slice to 16'h1234 shows on `hex` 1 cycle later.
- **All four contending** (from reset, `req`=4'b1111 held): grants go 0,1,2,3,0. Each holds exactly 4 cycles with no gap.
- **Early release:** owner 1 drops `req` after 2 cycles while requester 3 requests → next edge `gnt`=4'b1000, `dcnt`=0. With no other requesters → IDLE, `active`=0, `hex` keeps the last value.
- **Saturated hold:** only requester 0 requests for 10 cycles, then `req[2]` rises → `gnt` goes to 4'b0100 on the next edge.
- **Reset mid-HOLD:** pulse `rst` while owner=2 with `req`=4'b1111 → after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/hexdisp_arb.sv
// Round-robin owner of the eight-digit seven-segment display.
// The granted requester's live value shows on digits 0-3, its index on digit 4.
module hexdisp_arb #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DWELL    = CLK_FREQ
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [63:0] val,
    output logic [3:0]  gnt,
    output logic        active,
    output logic [1:0]  owner,
    output logic [55:0] hex
);
    localparam int DW = $clog2(DWELL);
    localparam logic [DW-1:0] DMAX = DW'(DWELL - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        r_state;
    logic [3:0]    r_gnt;
    logic          r_active;
    logic [1:0]    r_owner;
    logic [DW-1:0] r_dcnt;
    logic [15:0]   r_shown;

    state_t        w_nstate;
    logic [3:0]    w_ngnt;
    logic [1:0]    w_nowner;
    logic [DW-1:0] w_ndcnt;
    logic [15:0]   w_nshown;
    logic          w_found;
    logic [1:0]    w_pick;
    logic [1:0]    w_idx;
    logic          w_release;

    function automatic logic [6:0] hexdigit(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt    <= 4'b0000;
            r_active <= 1'b0;
            r_owner  <= 2'd3;
            r_dcnt   <= '0;
            r_shown  <= 16'h0000;
        end else begin
            r_state  <= w_nstate;
            r_gnt    <= w_ngnt;
            r_active <= (w_nstate == HOLD);
            r_owner  <= w_nowner;
            r_dcnt   <= w_ndcnt;
            r_shown  <= w_nshown;
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_owner;
        w_idx   = r_owner;
        // Scan lowest priority first so the highest-priority hit wins.
        for (int i = 4; i >= 1; i--) begin
            w_idx = r_owner + 2'(i);
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end

        w_nstate  = r_state;
        w_nowner  = r_owner;
        w_ndcnt   = r_dcnt;
        w_nshown  = r_shown;
        w_release = (r_state == IDLE) || !req[r_owner] || (r_dcnt == DMAX);

        if (w_release) begin
            if (w_found) begin
                w_nstate = HOLD;
                w_nowner = w_pick;
                w_nshown = val[{w_pick, 4'b0000} +: 16];
                if (r_state == HOLD && w_pick == r_owner)
                    w_ndcnt = r_dcnt;
                else
                    w_ndcnt = '0;
            end else begin
                w_nstate = IDLE;
            end
        end else begin
            w_ndcnt  = r_dcnt + 1'b1;
            w_nshown = val[{r_owner, 4'b0000} +: 16];
        end

        w_ngnt = (w_nstate == HOLD) ? (4'b0001 << w_nowner) : 4'b0000;
    end

    always_comb begin
        hex         = '0;
        hex[6:0]    = hexdigit(r_shown[3:0]);
        hex[13:7]   = hexdigit(r_shown[7:4]);
        hex[20:14]  = hexdigit(r_shown[11:8]);
        hex[27:21]  = hexdigit(r_shown[15:12]);
        hex[34:28]  = hexdigit({2'b00, r_owner});
        gnt         = r_gnt;
        active      = r_active;
        owner       = r_owner;
    end
endmodule
